// File: rtl/alu_op_sequencer.sv
// Issue sequencer between decode and the combinational ALU: decode, hold, capture, respond.
// Optional ALU_SEQ_PERF_EN builds the op/error counters; otherwise they are tied to 0.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_taken_o,
    output logic              rsp_err_o,
    output logic [31:0]       op_cnt_o,
    output logic [15:0]       err_cnt_o
);

    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_SLTI = 4'd3;
    localparam logic [3:0] C_SLT  = 4'd4;
    localparam logic [3:0] C_MUL  = 4'd5;
    localparam logic [3:0] C_SUB  = 4'd6;
    localparam logic [3:0] C_BEQ  = 4'd7;
    localparam logic [3:0] C_SRA  = 4'd8;
    localparam logic [3:0] C_SRAV = 4'd9;
    localparam logic [3:0] C_BNE  = 4'd10;
    localparam logic [3:0] C_LUI  = 4'd11;

    localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULW = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [3:0]        dec_ctrl;
    logic [DATA_W-1:0] dec_src1;
    logic [DATA_W-1:0] dec_src2;
    logic              dec_ok;
    logic              dec_mul;
    logic              cap_taken;

    always_comb begin
        dec_ctrl = C_AND;
        dec_src1 = rs_data_i;
        dec_src2 = rt_data_i;
        dec_ok   = 1'b1;
        unique case (aluop_i)
            3'b000: begin
                dec_ctrl = C_ADD;
                dec_src2 = imm_i;
            end
            3'b001: dec_ctrl = C_BEQ;
            3'b011: begin
                dec_ctrl = C_SLTI;
                dec_src2 = imm_i;
            end
            3'b100: dec_ctrl = C_BNE;
            3'b101: begin
                dec_ctrl = C_LUI;
                dec_src2 = imm_i;
            end
            3'b110: begin
                dec_ctrl = C_OR;
                dec_src2 = {{(DATA_W-16){1'b0}}, imm_i[15:0]};
            end
            3'b010: begin
                unique case (funct_i)
                    6'h20: dec_ctrl = C_ADD;
                    6'h22: dec_ctrl = C_SUB;
                    6'h24: dec_ctrl = C_AND;
                    6'h25: dec_ctrl = C_OR;
                    6'h2A: dec_ctrl = C_SLT;
                    6'h18: dec_ctrl = C_MUL;
                    6'h07: dec_ctrl = C_SRAV;
                    6'h03: begin
                        // shamt rides in imm[10:6]; the ALU picks it out
                        dec_ctrl = C_SRA;
                        dec_src1 = imm_i;
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            default: dec_ok = 1'b0;
        endcase
        dec_mul = (dec_ctrl == C_MUL);
    end

    assign cap_taken = ((alu_ctrl_o == C_BEQ) || (alu_ctrl_o == C_BNE)) & alu_zero_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready_o  <= 1'b1;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            alu_ctrl_o   <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_taken_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        if (!dec_ok) begin
                            // illegal ops never reach the ALU; its inputs keep old values
                            rsp_valid_o  <= 1'b1;
                            rsp_err_o    <= 1'b1;
                            rsp_result_o <= '0;
                            rsp_taken_o  <= 1'b0;
                            state        <= RESP;
                        end else begin
                            alu_src1_o <= dec_src1;
                            alu_src2_o <= dec_src2;
                            alu_ctrl_o <= dec_ctrl;
                            if (dec_mul) begin
                                cnt   <= MUL_INIT;
                                state <= MULW;
                            end else begin
                                state <= EXEC;
                            end
                        end
                    end
                end
                EXEC: begin
                    rsp_result_o <= alu_result_i;
                    rsp_taken_o  <= cap_taken;
                    rsp_err_o    <= 1'b0;
                    rsp_valid_o  <= 1'b1;
                    state        <= RESP;
                end
                MULW: begin
                    if (cnt == 4'd0) begin
                        rsp_result_o <= alu_result_i;
                        rsp_taken_o  <= cap_taken;
                        rsp_err_o    <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] op_cnt;
    logic [15:0] err_cnt;
    logic        rsp_fire;
    logic        err_fire;

    assign rsp_fire = rsp_valid_o & rsp_ready_i;
    assign err_fire = (state == IDLE) & req_valid_i & ~dec_ok;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (rsp_fire && (op_cnt != '1)) begin
                op_cnt <= op_cnt + 32'd1;
            end
            if (err_fire && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign op_cnt_o  = op_cnt;
    assign err_cnt_o = err_cnt;
`else
    assign op_cnt_o  = '0;
    assign err_cnt_o = '0;
`endif

endmodule
